// File: rtl/interp_sequencer.sv
// Control sequencer for the poly-phase interpolation path: commits each input sample to the FIR,
// steps through every phase, and hands each FIR result to the DAC serialiser.
module interp_sequencer #(
  parameter int unsigned PHASES  = 16,
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned FIR_LAT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_data_rdy,
  input  logic             i_shift_done,
  input  logic             i_clr_ovr,
  output logic             o_sample_load,
  output logic             o_fir_en,
  output logic [SEL_W-1:0] o_fir_sel,
  output logic             o_sample_rdy,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int unsigned      WaitW     = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;
  localparam logic [WaitW-1:0] WaitInit  = WaitW'(FIR_LAT - 1);
  localparam logic [SEL_W-1:0] LastPhase = SEL_W'(PHASES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPhase,
    StWaitFir,
    StOut,
    StWaitShift
  } state_t;

  state_t           r_state, w_state_next;
  logic [SEL_W-1:0] r_phase, w_phase_next;
  logic [WaitW-1:0] r_wait,  w_wait_next;
  logic             r_pend,  w_pend_next;
  logic             r_ovr,   w_ovr_next;
  logic             w_frame_end;
  logic             w_ovr_set;

  // Final shift_done of the frame: the only point where a pending sample is consumed.
  assign w_frame_end = (r_state == StWaitShift) && i_shift_done && (r_phase == LastPhase);

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_wait_next  = r_wait;
    unique case (r_state)
      StIdle: begin
        if (i_data_rdy) w_state_next = StLoad;
      end
      StLoad: begin
        w_phase_next = '0;
        w_state_next = StPhase;
      end
      StPhase: begin
        w_wait_next  = WaitInit;
        w_state_next = StWaitFir;
      end
      StWaitFir: begin
        if (r_wait == '0) w_state_next = StOut;
        else              w_wait_next  = r_wait - WaitW'(1);
      end
      StOut: begin
        w_state_next = StWaitShift;
      end
      StWaitShift: begin
        if (i_shift_done) begin
          if (r_phase != LastPhase) begin
            w_phase_next = r_phase + SEL_W'(1);
            w_state_next = StPhase;
          end else if (r_pend || i_data_rdy) begin
            w_state_next = StLoad;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_pend_next = r_pend;
    w_ovr_set   = 1'b0;
    if (w_frame_end) begin
      // A sample arriving as the buffered one is consumed takes its place; one arriving with
      // nothing buffered is used directly by the LOAD.
      w_pend_next = r_pend & i_data_rdy;
    end else if ((r_state != StIdle) && i_data_rdy) begin
      w_pend_next = 1'b1;
      w_ovr_set   = r_pend;
    end
    w_ovr_next = (r_ovr & ~i_clr_ovr) | w_ovr_set;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_phase <= '0;
      r_wait  <= '0;
      r_pend  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_wait  <= w_wait_next;
      r_pend  <= w_pend_next;
      r_ovr   <= w_ovr_next;
    end
  end

  assign o_sample_load = (r_state == StLoad);
  assign o_fir_en      = (r_state == StPhase);
  assign o_sample_rdy  = (r_state == StOut);
  assign o_busy        = (r_state != StIdle);
  assign o_fir_sel     = r_phase;
  assign o_overrun     = r_ovr;

endmodule

// File: tb/tb_interp_sequencer.sv
// Randomised bench for interp_sequencer against a frame/phase timing model.
module tb_interp_sequencer;

  localparam int Phases = 16;
  localparam int SelW   = 5;
  localparam int FirLat = 2;
  localparam int OutT   = FirLat + 1;  // offset of sample_rdy from fir_en
  localparam int WsT    = FirLat + 2;  // first offset spent waiting for the serialiser

  logic            clk = 1'b0;
  logic            rst;
  logic            data_rdy, shift_done, clr_ovr;
  logic            sample_load, fir_en, sample_rdy, busy, overrun;
  logic [SelW-1:0] fir_sel;

  always #5 clk = ~clk;

  interp_sequencer #(
    .PHASES (Phases),
    .SEL_W  (SelW),
    .FIR_LAT(FirLat)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_rdy   (data_rdy),
    .i_shift_done (shift_done),
    .i_clr_ovr    (clr_ovr),
    .o_sample_load(sample_load),
    .o_fir_en     (fir_en),
    .o_fir_sel    (fir_sel),
    .o_sample_rdy (sample_rdy),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a frame is busy; m_t is the cycle offset within the current phase
  // (-1 = load cycle, 0 = fir_en, OutT = sample_rdy, >= WsT = waiting for shift_done).
  bit m_busy, m_pend, m_ovr;
  int m_t, m_phase;

  int unsigned dr_pct, spur_pct, clr_pml, sd_min, sd_max;
  int          sd_cnt;
  bit          g_last_dr;
  int          fe_cnt, rdy_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_ovr = 0; m_t = 0; m_phase = 0; sd_cnt = 0;
  endtask

  task automatic check_outputs();
    logic [4:0] obs, exp;
    bit         e_en, e_rdy;
    e_en  = m_busy && (m_t == 0);
    e_rdy = m_busy && (m_t == OutT);
    obs   = {sample_load, fir_en, sample_rdy, busy, overrun};
    exp   = {m_busy && (m_t == -1), e_en, e_rdy, m_busy, m_ovr};
    check_eq("ld_en_rdy_busy_ovr", 32'(obs), 32'(exp));
    if (e_en || e_rdy) check_eq("fir_sel", 32'(fir_sel), 32'(m_phase));
    fe_cnt  += int'(fir_en);
    rdy_cnt += int'(sample_rdy);
  endtask

  task automatic model_update(input bit dr, input bit sd, input bit clr);
    bit acc, last, ev, was_busy;
    acc      = m_busy && (m_t >= WsT) && sd;
    last     = acc && (m_phase == Phases - 1);
    ev       = dr && m_busy && m_pend && !last;
    was_busy = m_busy;
    if (!m_busy) begin
      if (dr) begin m_busy = 1; m_t = -1; end
    end else if (m_t < WsT) begin
      if (m_t == -1) m_phase = 0;
      m_t++;
    end else if (acc) begin
      if (!last) begin m_phase++; m_t = 0; end
      else if (m_pend || dr) m_t = -1;
      else m_busy = 0;
    end
    if (was_busy) begin
      if (last) m_pend = m_pend & dr;
      else if (dr) m_pend = 1;
    end
    m_ovr = (m_ovr && !clr) || ev;
  endtask

  task automatic step(input bit dr, input bit sd, input bit clr);
    @(negedge clk);
    check_outputs();
    data_rdy = dr; shift_done = sd; clr_ovr = clr;
    model_update(dr, sd, clr);
  endtask

  task automatic rand_cycle(input bit force_dr);
    bit sd, dr, clr, e_rdy;
    sd = 0;
    if (sd_cnt > 0) begin
      sd_cnt--;
      if (sd_cnt == 0) sd = 1;
    end
    if ($urandom_range(99) < spur_pct) sd = 1;
    dr  = force_dr || ($urandom_range(99) < dr_pct);
    clr = $urandom_range(999) < clr_pml;
    if (g_last_dr && sd && m_busy && (m_t >= WsT) && (m_phase == Phases - 1)) begin
      dr = 1; g_last_dr = 0;
    end
    e_rdy = m_busy && (m_t == OutT);
    step(dr, sd, clr);
    if (e_rdy) sd_cnt = int'($urandom_range(sd_max, sd_min));
  endtask

  task automatic run_until_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (m_busy && n < limit) begin
      rand_cycle(0);
      n++;
    end
    if (m_busy) check_eq({tag, "_drain_timeout"}, 32'(busy), 32'(0));
    rand_cycle(0);
  endtask

  // One frame started from idle, with optional data_rdy injections at the fir_en of given phases.
  task automatic run_frames(input string tag, input int inj_a, input int inj_b, input bit last_dr,
                            input int exp_rdy, input bit exp_ovr);
    bit done_a, done_b, f;
    int n;
    fe_cnt = 0; rdy_cnt = 0; done_a = 0; done_b = 0; g_last_dr = last_dr; n = 0;
    rand_cycle(1);
    while (m_busy && n < 4000) begin
      f = 0;
      if (m_t == 0 && m_phase == inj_a && !done_a) begin f = 1; done_a = 1; end
      if (m_t == 0 && m_phase == inj_b && !done_b) begin f = 1; done_b = 1; end
      rand_cycle(f);
      n++;
    end
    if (m_busy) check_eq({tag, "_timeout"}, 32'(busy), 32'(0));
    g_last_dr = 0;
    rand_cycle(0);
    check_eq({tag, "_rdy_count"}, 32'(rdy_cnt), 32'(exp_rdy));
    check_eq({tag, "_en_count"}, 32'(fe_cnt), 32'(exp_rdy));
    check_eq({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    int n;
    rst = 1; data_rdy = 0; shift_done = 0; clr_ovr = 0;
    dr_pct = 0; spur_pct = 0; clr_pml = 0; sd_min = 3; sd_max = 3; g_last_dr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    step(0, 0, 0);
    check_eq("reset_sel", 32'(fir_sel), 32'(0));
    check_eq("reset_outs", 32'({sample_load, fir_en, sample_rdy, busy, overrun}), 32'(0));

    run_frames("single", -1, -1, 0, Phases, 0);
    run_frames("pending", 7, -1, 0, 2 * Phases, 0);
    run_frames("overrun", 3, 10, 0, 2 * Phases, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    check_eq("ovr_cleared", 32'(overrun), 32'(0));
    run_frames("last_edge", 5, -1, 1, 3 * Phases, 0);

    // Spurious shift_done while idle, then a frame with frequent spurious pulses.
    repeat (3) step(0, 1, 0);
    spur_pct = 20; sd_min = 1; sd_max = 4;
    run_frames("spurious", -1, -1, 0, Phases, 0);
    spur_pct = 0; sd_min = 3; sd_max = 3;

    // Asynchronous reset while waiting for the serialiser in phase 9, with overrun set.
    rand_cycle(1);
    n = 0;
    while (!(m_busy && m_phase == 9 && m_t >= WsT) && n < 500) begin
      rand_cycle(m_t == 0 && (m_phase == 2 || m_phase == 4));
      n++;
    end
    check_eq("pre_rst_ovr", 32'(overrun), 32'(1));
    #2 rst = 1;
    #1 check_eq("async_rst_outs", 32'({sample_load, fir_en, sample_rdy, busy, overrun}), 32'(0));
    check_eq("async_rst_sel", 32'(fir_sel), 32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0; data_rdy = 0; shift_done = 0; clr_ovr = 0;
    repeat (4) rand_cycle(0);
    rand_cycle(1);
    rand_cycle(0);
    rand_cycle(0);
    check_eq("restart_en", 32'(fir_en), 32'(1));
    check_eq("restart_sel", 32'(fir_sel), 32'(0));
    run_until_idle("restart", 2000);

    // Random soak.
    dr_pct = 2; spur_pct = 4; clr_pml = 5; sd_min = 1; sd_max = 5;
    for (int i = 0; i < 4000; i++) rand_cycle(0);
    dr_pct = 0; spur_pct = 0; clr_pml = 0;
    run_until_idle("soak", 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/interp_sequencer.md
# interp_sequencer

Control sequencer for the poly-phase interpolation path. It sits between the PCM2706 input interface, the poly-phase FIR, and the PCM1702 output interface. For each input sample it commits the sample to the FIR delay line, then steps through all interpolation phases: it enables the FIR, waits out the FIR latency, and hands each result to the DAC serialiser, waiting for its shift to finish. It replaces the ad-hoc state machine plus external phase counter, and adds input-overrun buffering and detection.

## Interface
- PHASES, 16, interpolation factor; number of FIR phases per input sample; 2 to 2^SEL_W.
- SEL_W, 5, width of fir_sel.
- FIR_LAT, 2, clock cycles from fir_en to a valid outputSample; minimum 1.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_rdy  in  1  one-cycle pulse: a new input sample is valid on the interface's parallel output.
- shift_done  in  1  one-cycle pulse from the DAC serialiser: the current word has been shifted out.
- clr_ovr  in  1  synchronous clear for overrun.
- sample_load  out  1  one-cycle strobe: FIR latches the input sample into its delay line.
- fir_en  out  1  one-cycle strobe: FIR computes the phase selected by fir_sel.
- fir_sel  out  SEL_W  current phase index, 0 to PHASES-1.
- sample_rdy  out  1  one-cycle strobe: outputSample is valid; DAC serialiser starts shifting.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: an input sample was dropped.

## Operation
- States: IDLE, LOAD, PHASE, WAIT_FIR, OUT, WAIT_SHIFT. The state register, phase counter, wait counter, pending flag and overrun flag are all registered.
- Outputs are decoded from the registered state only:
  - sample_load = (state==LOAD)
  - fir_en = (state==PHASE)
  - sample_rdy = (state==OUT)
  - busy = (state!=IDLE)
  - fir_sel = phase counter, which is held stable from PHASE through WAIT_SHIFT.
- Transitions:
  - IDLE: data_rdy -> LOAD.
  - LOAD: phase<=0 -> PHASE.
  - PHASE: wait counter <= FIR_LAT-1 -> WAIT_FIR.
  - WAIT_FIR: decrement; at 0 -> OUT.
  - OUT -> WAIT_SHIFT unconditionally.
  - WAIT_SHIFT:
    - shift_done with phase<PHASES-1: phase<=phase+1 -> PHASE.
    - shift_done with phase==PHASES-1: -> LOAD if pending or data_rdy this cycle (pending<=0), else -> IDLE.
    - No shift_done: hold.
- Pending buffer (one deep):
  - data_rdy in any state other than IDLE sets pending.
  - If pending is already 1 and not being consumed this cycle, the sample is dropped and overrun<=1.
  - data_rdy in the same cycle pending is consumed (end-of-frame transition to LOAD) leaves pending=1 and does not set overrun.
- overrun clears only on rst or clr_ovr. If clr_ovr and a new overrun event occur in the same cycle, overrun is set.
- shift_done outside WAIT_SHIFT is ignored.
- Phase counter wraps only via LOAD; it never exceeds PHASES-1.

## Timing
- Reset values: state=IDLE, phase=0, wait counter=0, pending=0, overrun=0. Resulting outputs: sample_load=0, fir_en=0, fir_sel=0, sample_rdy=0, busy=0, overrun=0.
- Reset mid-frame aborts immediately (asynchronous). No further strobes are issued until a new data_rdy arrives.
- data_rdy sampled at edge N:
  - sample_load high in cycle N+1.
  - fir_en high with fir_sel=0 in cycle N+2.
  - sample_rdy high in cycle N+3+FIR_LAT (N+5 at defaults).
- shift_done sampled at edge M (non-last phase): fir_en for the next phase in cycle M+1, sample_rdy in cycle M+2+FIR_LAT.
- Frame length: PHASES*(2+FIR_LAT) + 1 + (sum of serialiser wait cycles) clocks.
- Every strobe is exactly one cycle wide. There is at most one outstanding sample_rdy, and sample_rdy never reasserts before shift_done.

## Test plan
- Reset then a single data_rdy, with shift_done returned 3 cycles after each sample_rdy, defaults -> sample_load cycle 1; fir_sel 0..15 with exactly 16 fir_en and 16 sample_rdy pulses; busy drops after the 16th shift_done; overrun=0.
- data_rdy during phase 7, then frame end -> pending set; transition directly to LOAD the cycle after the 16th shift_done with no IDLE cycle; second frame completes normally.
- Two data_rdy pulses during one frame -> overrun=1 after the second; only one extra frame is run. clr_ovr pulse -> overrun=0.
- data_rdy on the same edge as the final shift_done, with pending=1 -> LOAD taken, pending stays 1, overrun stays 0.
- Spurious shift_done during WAIT_FIR and IDLE -> ignored: no phase advance and no extra sample_rdy.
- rst asserted asynchronously in WAIT_SHIFT at phase 9 -> all outputs 0 immediately; the next data_rdy restarts at fir_sel=0.
